// File: rtl/tone_bank_if.sv
// Register-file side of the tone bank: prescaler tick, shared period write port,
// per-channel phase resets and the registered tone/flip outputs.
interface tone_bank_if #(
  parameter int CHANNELS     = 3,
  parameter int COUNTER_BITS = 10
) ();
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    enable;
  logic                    wr_en;
  logic [CH_BITS-1:0]      wr_channel;
  logic [COUNTER_BITS-1:0] wr_period;
  logic [CHANNELS-1:0]     phase_reset;
  logic [CHANNELS-1:0]     out;
  logic [CHANNELS-1:0]     flip;

  modport master (
    output enable, wr_en, wr_channel, wr_period, phase_reset,
    input  out, flip
  );

  modport slave (
    input  enable, wr_en, wr_channel, wr_period, phase_reset,
    output out, flip
  );
endinterface

// File: rtl/tone_bank.sv
// Bank of independent square-wave tone channels: down-counter per channel, reload on zero,
// output flip with a one-cycle strobe that also clocks the noise generator.
module tone_bank #(
  parameter int CHANNELS     = 3,
  parameter int COUNTER_BITS = 10,
  parameter int ZERO_MODE    = 0,
  parameter int SYNC_UPDATE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  tone_bank_if.slave bus
);
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [COUNTER_BITS-1:0] count_t;

  count_t              period_q  [CHANNELS];
  count_t              pending_q [CHANNELS];
  count_t              count_q   [CHANNELS];
  logic [CHANNELS-1:0] pend_flag;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] flip_q;

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] reload;
  count_t              reload_src [CHANNELS];
  count_t              reload_val [CHANNELS];

  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      wr_hit[ch] = bus.wr_en && (bus.wr_channel == CH_BITS'(ch));
      reload[ch] = bus.enable && !bus.phase_reset[ch] && (count_q[ch] == '0);

      // A write landing on the reload cycle wins over both the pending and active period.
      if (wr_hit[ch]) begin
        reload_src[ch] = bus.wr_period;
      end else if ((SYNC_UPDATE != 0) && pend_flag[ch]) begin
        reload_src[ch] = pending_q[ch];
      end else begin
        reload_src[ch] = period_q[ch];
      end

      // Period 0 wraps to all-ones (TI) unless the VDP reading of one enable is selected.
      if ((ZERO_MODE != 0) && (reload_src[ch] == '0)) begin
        reload_val[ch] = '0;
      end else begin
        reload_val[ch] = reload_src[ch] - count_t'(1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every channel sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the period and pending registers are cleared by reset too; software relies on
      // a known period 0 after reset, so they are not left as uninitialised storage.
      for (int ch = 0; ch < CHANNELS; ch++) begin
        period_q[ch]  <= '0;
        pending_q[ch] <= '0;
        count_q[ch]   <= '0;
      end
      pend_flag <= '0;
      out_q     <= '0;
      flip_q    <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        flip_q[ch] <= 1'b0;
        if (bus.phase_reset[ch]) begin
          count_q[ch] <= '0;
          out_q[ch]   <= 1'b0;
        end else if (reload[ch]) begin
          count_q[ch] <= reload_val[ch];
          out_q[ch]   <= ~out_q[ch];
          flip_q[ch]  <= 1'b1;
        end else if (bus.enable) begin
          count_q[ch] <= count_q[ch] - count_t'(1);
        end

        if (SYNC_UPDATE == 0) begin
          if (wr_hit[ch]) begin
            period_q[ch] <= bus.wr_period;
          end
        end else if (reload[ch]) begin
          // Whatever fed this reload becomes the active period; any pending write is consumed.
          period_q[ch]  <= reload_src[ch];
          pend_flag[ch] <= 1'b0;
        end else if (wr_hit[ch]) begin
          pending_q[ch] <= bus.wr_period;
          pend_flag[ch] <= 1'b1;
        end
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.flip = flip_q;
endmodule

// File: tb/tb_tone_bank.sv
// Scoreboard bench for tone_bank: three instances (TI/async, VDP/async, TI/sync) share one
// stimulus stream; a half-period model predicts out/flip, directed checks cover internals.
module tb_tone_bank;
  localparam int CHANNELS     = 3;
  localparam int COUNTER_BITS = 10;
  localparam int NDUT         = 3;
  localparam logic [NDUT-1:0] ZM = 3'b010;
  localparam logic [NDUT-1:0] SU = 3'b100;

  typedef logic [COUNTER_BITS-1:0] per_t;
  typedef struct packed {
    logic [NDUT-1:0][CHANNELS-1:0] out;
    logic [NDUT-1:0][CHANNELS-1:0] flip;
  } exp_t;

  logic                clk         = 1'b0;
  logic                reset       = 1'b1;
  logic                enable      = 1'b0;
  logic                wr_en       = 1'b0;
  logic [1:0]          wr_channel  = '0;
  per_t                wr_period   = '0;
  logic [CHANNELS-1:0] phase_reset = '0;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   flip_cnt [NDUT][CHANNELS];

  per_t                m_period [NDUT][CHANNELS];
  per_t                m_pend   [NDUT][CHANNELS];
  logic                m_pflag  [NDUT][CHANNELS];
  per_t                m_remain [NDUT][CHANNELS];
  logic [CHANNELS-1:0] m_out    [NDUT];
  logic [CHANNELS-1:0] m_flip   [NDUT];

  logic [CHANNELS-1:0] obs_out  [NDUT];
  logic [CHANNELS-1:0] obs_flip [NDUT];

  always #5 clk = ~clk;

  tone_bank_if #(.CHANNELS(CHANNELS), .COUNTER_BITS(COUNTER_BITS)) bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].enable      = enable;
    assign bus[g].wr_en       = wr_en;
    assign bus[g].wr_channel  = wr_channel;
    assign bus[g].wr_period   = wr_period;
    assign bus[g].phase_reset = phase_reset;
    assign obs_out[g]         = bus[g].out;
    assign obs_flip[g]        = bus[g].flip;

    tone_bank #(
      .CHANNELS    (CHANNELS),
      .COUNTER_BITS(COUNTER_BITS),
      .ZERO_MODE   (int'(ZM[g])),
      .SYNC_UPDATE (int'(SU[g]))
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Model in half-period terms: remain = enables still to wait before the next toggle.
  task automatic model_step();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        logic hit;
        per_t p;
        int   half;
        hit = wr_en && (int'(wr_channel) == ch);
        if (reset) begin
          m_period[d][ch] = '0;
          m_pend[d][ch]   = '0;
          m_pflag[d][ch]  = 1'b0;
          m_remain[d][ch] = '0;
          m_out[d][ch]    = 1'b0;
          m_flip[d][ch]   = 1'b0;
        end else begin
          m_flip[d][ch] = 1'b0;
          if (hit) p = wr_period;
          else if (SU[d] && m_pflag[d][ch]) p = m_pend[d][ch];
          else p = m_period[d][ch];
          if (phase_reset[ch]) begin
            m_remain[d][ch] = '0;
            m_out[d][ch]    = 1'b0;
          end else if (enable && m_remain[d][ch] == 0) begin
            half = (p == 0) ? (ZM[d] ? 1 : 1024) : int'(p);
            m_remain[d][ch] = per_t'(half - 1);
            m_out[d][ch]    = ~m_out[d][ch];
            m_flip[d][ch]   = 1'b1;
            if (SU[d]) begin
              m_period[d][ch] = p;
              m_pflag[d][ch]  = 1'b0;
              hit = 1'b0;
            end
          end else if (enable) begin
            m_remain[d][ch] = m_remain[d][ch] - 1'b1;
          end
          if (hit) begin
            if (SU[d]) begin
              m_pend[d][ch]  = wr_period;
              m_pflag[d][ch] = 1'b1;
            end else begin
              m_period[d][ch] = wr_period;
            end
          end
        end
      end
      e.out[d]  = m_out[d];
      e.flip[d] = m_flip[d];
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic en, input logic we, input logic [1:0] ch,
                       input per_t per, input logic [CHANNELS-1:0] pr);
    @(negedge clk);
    reset       = rst;
    enable      = en;
    wr_en       = we;
    wr_channel  = ch;
    wr_period   = per;
    phase_reset = pr;
    model_step();
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_flips();
    for (int d = 0; d < NDUT; d++)
      for (int ch = 0; ch < CHANNELS; ch++) flip_cnt[d][ch] = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("out%0d", d), 32'(obs_out[d]), 32'(e.out[d]));
        check($sformatf("flip%0d", d), 32'(obs_flip[d]), 32'(e.flip[d]));
        for (int ch = 0; ch < CHANNELS; ch++) if (obs_flip[d][ch] === 1'b1) flip_cnt[d][ch]++;
      end
    end
  end

  initial begin
    clear_flips();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, '0, '0);
    settle();
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("rst_per%0d", ch), 32'(g_dut[0].dut.period_q[ch]), 32'd0);
      check($sformatf("rst_cnt%0d", ch), 32'(g_dut[0].dut.count_q[ch]), 32'd0);
    end

    // T1: ch0 period 3, ch1/ch2 left at period 0
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 10'd3, '0);
    settle();
    check("t1_per_a", 32'(g_dut[0].dut.period_q[0]), 32'd3);
    check("t1_pend_c", 32'(g_dut[2].dut.pending_q[0]), 32'd3);
    check("t1_pflag_c", 32'(g_dut[2].dut.pend_flag[0]), 32'd1);
    clear_flips();
    run(30, 1'b1);
    settle();
    check("t1_flips_a0", flip_cnt[0][0], 10);
    check("t1_per_c", 32'(g_dut[2].dut.period_q[0]), 32'd3);

    // T2: period 0 in both zero modes, then period 1
    clear_flips();
    run(1100, 1'b1);
    settle();
    check("t2_zm0_ch1", flip_cnt[0][1], 1);
    check("t2_zm1_ch1", flip_cnt[1][1], 1100);
    check("t2_zm1_ch2", flip_cnt[1][2], 1100);
    check("t2_sync_ch2", flip_cnt[2][2], 1);
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 10'd1, 3'b100);
    clear_flips();
    run(10, 1'b1);
    settle();
    for (int d = 0; d < NDUT; d++) check($sformatf("t2_p1_%0d", d), flip_cnt[d][2], 10);

    // T3: ch1 P=10, rewrite to 2 four enables after a toggle
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 10'd10, 3'b010);
    settle();
    check("t3_per_a", 32'(g_dut[0].dut.period_q[1]), 32'd10);
    check("t3_pend_c", 32'(g_dut[2].dut.pending_q[1]), 32'd10);
    clear_flips();
    run(5, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 10'd2, '0);
    settle();
    check("t3_new_a", 32'(g_dut[0].dut.period_q[1]), 32'd2);
    check("t3_old_c", 32'(g_dut[2].dut.period_q[1]), 32'd10);
    check("t3_pflag_c", 32'(g_dut[2].dut.pend_flag[1]), 32'd1);
    run(30, 1'b1);
    settle();
    check("t3_flips_a", flip_cnt[0][1], 14);
    check("t3_flips_c", flip_cnt[2][1], 14);
    check("t3_per_c", 32'(g_dut[2].dut.period_q[1]), 32'd2);
    check("t3_pclr_c", 32'(g_dut[2].dut.pend_flag[1]), 32'd0);

    // T4: phase reset with enable while out[2] is high
    for (int i = 0; i < 4 && m_out[0][2] != 1'b1; i++) run(1, 1'b1);
    settle();
    check("t4_pre_out", 32'(obs_out[0][2]), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, '0, 3'b100);
    settle();
    check("t4_out", 32'(obs_out[0][2]), 32'd0);
    check("t4_flip", 32'(obs_flip[0][2]), 32'd0);
    check("t4_cnt", 32'(g_dut[0].dut.count_q[2]), 32'd0);
    run(1, 1'b1);
    settle();
    check("t4_out_up", 32'(obs_out[0][2]), 32'd1);
    check("t4_flip_up", 32'(obs_flip[0][2]), 32'd1);

    // T5: out-of-range write, frozen counters, write/reload collision
    cycle(1'b0, 1'b0, 1'b1, 2'd3, 10'd77, '0);
    settle();
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("t5_per%0d", ch), 32'(g_dut[0].dut.period_q[ch]), 32'(m_period[0][ch]));
      check($sformatf("t5_pfl%0d", ch), 32'(g_dut[2].dut.pend_flag[ch]), 32'(m_pflag[2][ch]));
    end
    clear_flips();
    run(50, 1'b0);
    settle();
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("t5_cnt%0d", ch), 32'(g_dut[0].dut.count_q[ch]), 32'(m_remain[0][ch]));
      check($sformatf("t5_idle%0d", ch), flip_cnt[0][ch] + flip_cnt[1][ch] + flip_cnt[2][ch], 0);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'd0, '0, 3'b001);
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 10'd5, '0);
    settle();
    check("t5_col_cnt_a", 32'(g_dut[0].dut.count_q[0]), 32'd4);
    check("t5_col_cnt_c", 32'(g_dut[2].dut.count_q[0]), 32'd4);
    check("t5_col_per_c", 32'(g_dut[2].dut.period_q[0]), 32'd5);
    run(12, 1'b1);

    // Mixed traffic: random enables, writes (including invalid channel 3) and phase resets
    for (int i = 0; i < 400; i++) begin
      logic [CHANNELS-1:0] pr;
      for (int ch = 0; ch < CHANNELS; ch++) pr[ch] = ($urandom_range(0, 15) == 0);
      cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)), per_t'($urandom_range(0, 6)), pr);
    end

    // T6: reset mid-count beats enable and a simultaneous write
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 10'd9, 3'b010);
    settle();
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("t6_per%0d", ch), 32'(g_dut[0].dut.period_q[ch]), 32'd0);
      check($sformatf("t6_pend%0d", ch), 32'(g_dut[2].dut.pending_q[ch]), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b0, 2'd0, '0, '0);
    settle();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("t6_out%0d", d), 32'(obs_out[d]), 32'h7);
      check($sformatf("t6_flip%0d", d), 32'(obs_flip[d]), 32'h7);
    end
    run(4, 1'b1);
    settle();
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
